// File: rtl/ej32_ifetch.sv
// eJ32 bytecode fetch: reads opcode/operand bytes, assembles a big-endian argument, presents one instruction.
// Define EJ32_FVM_EXT_EN to decode the FVM extended opcodes (0xca-0xd1) instead of flagging them as errors.
module ej32_ifetch #(
    parameter int              ASZ    = 16,
    parameter int              DSZ    = 32,
    parameter logic [ASZ-1:0]  RST_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_req,
    output logic [ASZ-1:0] mem_adr,
    input  logic           mem_ack,
    input  logic [7:0]     mem_data,
    input  logic           jmp,
    input  logic [ASZ-1:0] jmp_pc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_op,
    output logic [DSZ-1:0] out_arg,
    output logic [2:0]     out_len,
    output logic [ASZ-1:0] out_pc,
    output logic           out_err
);

    typedef enum logic [1:0] {S_OP, S_ARG, S_OUT} state_t;

    typedef enum logic [7:0] {
        OP_NOP          = 8'h00, OP_BIPUSH      = 8'h10, OP_SIPUSH     = 8'h11,
        OP_LDC          = 8'h12, OP_LDC_W       = 8'h13, OP_LDC2_W     = 8'h14,
        OP_IINC         = 8'h84, OP_GOTO        = 8'ha7, OP_JSR        = 8'ha8,
        OP_RET          = 8'ha9, OP_TABLESWITCH = 8'haa, OP_LOOKUPSW   = 8'hab,
        OP_INVOKEINTF   = 8'hb9, OP_INVOKEDYN   = 8'hba, OP_JNEW       = 8'hbb,
        OP_NEWARRAY     = 8'hbc, OP_ANEWARRAY   = 8'hbd, OP_CHECKCAST  = 8'hc0,
        OP_INSTANCEOF   = 8'hc1, OP_WIDE        = 8'hc4, OP_MULTIANEW  = 8'hc5,
        OP_IFNULL       = 8'hc6, OP_IFNONNULL   = 8'hc7, OP_GOTO_W     = 8'hc8,
        OP_JSR_W        = 8'hc9, OP_DONEXT      = 8'hca, OP_LDI        = 8'hcb,
        OP_POPR         = 8'hcc, OP_PUSHR       = 8'hcd, OP_DUPR       = 8'hce,
        OP_EXT          = 8'hcf, OP_GET         = 8'hd0, OP_PUT        = 8'hd1,
        OP_INVALID      = 8'hff
    } opcode_t;

    state_t         r_state;
    logic [ASZ-1:0] r_pc;
    logic           r_mem_req;
    logic [2:0]     r_cnt;
    logic           r_sgn;
    logic           r_out_valid;
    logic [7:0]     r_out_op;
    logic [DSZ-1:0] r_out_arg;
    logic [2:0]     r_out_len;
    logic [ASZ-1:0] r_out_pc;
    logic           r_out_err;

    logic [2:0]     w_len;
    logic           w_sgn;
    logic           w_err;
    logic [DSZ-1:0] w_shift;

    // NOTE: every decode output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_len = 3'd0;
        w_sgn = 1'b0;
        w_err = 1'b0;
        case (mem_data) inside
            OP_BIPUSH:                                       begin w_len = 3'd1; w_sgn = 1'b1; end
            OP_LDC, [8'h15:8'h19], [8'h36:8'h3a], OP_RET,
            OP_NEWARRAY:                                     w_len = 3'd1;
            OP_SIPUSH, [8'h99:8'ha6], OP_GOTO, OP_JSR,
            OP_IFNULL, OP_IFNONNULL:                         begin w_len = 3'd2; w_sgn = 1'b1; end
            OP_LDC_W, OP_LDC2_W, OP_IINC, [8'hb2:8'hb8], OP_JNEW,
            OP_ANEWARRAY, OP_CHECKCAST, OP_INSTANCEOF:       w_len = 3'd2;
            OP_MULTIANEW:                                    w_len = 3'd3;
            OP_INVOKEINTF, OP_INVOKEDYN, OP_GOTO_W, OP_JSR_W: w_len = 3'd4;
`ifdef EJ32_FVM_EXT_EN
            OP_DONEXT:                                       begin w_len = 3'd2; w_sgn = 1'b1; end
            OP_LDI:                                          w_len = 3'd4;
`else
            [OP_DONEXT:OP_PUT]:                              w_err = 1'b1;
`endif
            OP_TABLESWITCH, OP_LOOKUPSW, OP_WIDE, OP_INVALID: w_err = 1'b1;
            default: ;
        endcase
    end

    // The presented argument register doubles as the operand shift accumulator.
    assign w_shift = {r_out_arg[DSZ-9:0], mem_data};

    function automatic logic [DSZ-1:0] extend(input logic [DSZ-1:0] v, input logic [2:0] n,
                                              input logic sgn);
        logic top;
        case (n)
            3'd1:    top = v[7];
            3'd2:    top = v[15];
            3'd3:    top = v[23];
            default: top = v[DSZ-1];
        endcase
        return (sgn && top) ? (v | ({DSZ{1'b1}} << {n, 3'b000})) : v;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_OP;
            r_pc        <= RST_PC;
            r_mem_req   <= 1'b0;
            r_cnt       <= 3'd0;
            r_sgn       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_op    <= 8'h00;
            r_out_arg   <= '0;
            r_out_len   <= 3'd0;
            r_out_pc    <= '0;
            r_out_err   <= 1'b0;
        end else if (jmp) begin
            // Redirect wins over any same-cycle ack; an accepted transfer needs no extra action.
            r_state     <= S_OP;
            r_pc        <= jmp_pc;
            r_mem_req   <= 1'b1;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_OP: begin
                    if (r_mem_req && mem_ack) begin
                        r_out_op  <= mem_data;
                        r_out_pc  <= r_pc;
                        r_out_len <= w_len;
                        r_out_err <= w_err;
                        r_out_arg <= '0;
                        r_sgn     <= w_sgn;
                        r_cnt     <= w_len;
                        r_pc      <= r_pc + 1'b1;
                        if (w_len == 3'd0) begin
                            r_out_valid <= 1'b1;
                            r_mem_req   <= 1'b0;
                            r_state     <= S_OUT;
                        end else begin
                            r_state <= S_ARG;
                        end
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                S_ARG: begin
                    if (mem_ack) begin
                        r_pc  <= r_pc + 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == 3'd1) begin
                            r_out_arg   <= extend(w_shift, r_out_len, r_sgn);
                            r_out_valid <= 1'b1;
                            r_mem_req   <= 1'b0;
                            r_state     <= S_OUT;
                        end else begin
                            r_out_arg <= w_shift;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_OP;
                    end
                end
                default: r_state <= S_OP;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_adr   = r_pc;
    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_arg   = r_out_arg;
    assign out_len   = r_out_len;
    assign out_pc    = r_out_pc;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_ej32_ifetch.sv
// Self-checking bench for ej32_ifetch: directed scenarios plus a randomized stream checked
// against a table-driven instruction model reading the same byte memory.
module tb_ej32_ifetch;
    localparam int ASZ = 16;
    localparam int DSZ = 32;

    typedef struct packed {
        logic [7:0]     op;
        logic [DSZ-1:0] arg;
        logic [2:0]     len;
        logic [ASZ-1:0] pc;
        logic           err;
    } instr_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           mem_req;
    logic [ASZ-1:0] mem_adr;
    logic           mem_ack = 1'b0;
    logic [7:0]     mem_data = 8'h00;
    logic           jmp = 1'b0;
    logic [ASZ-1:0] jmp_pc = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [7:0]     out_op;
    logic [DSZ-1:0] out_arg;
    logic [2:0]     out_len;
    logic [ASZ-1:0] out_pc;
    logic           out_err;

    ej32_ifetch #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_data(mem_data),
        .jmp(jmp), .jmp_pc(jmp_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_arg(out_arg), .out_len(out_len), .out_pc(out_pc), .out_err(out_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int         len_tab [256];
    bit         sgn_tab [256];
    bit         err_tab [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         stall_left = 0;
    int         stall_pct  = 0;

    function automatic instr_t mk(input logic [7:0] op, input logic [DSZ-1:0] arg,
                                  input logic [2:0] len, input logic [ASZ-1:0] pc, input logic err);
        instr_t r;
        r.op = op; r.arg = arg; r.len = len; r.pc = pc; r.err = err;
        return r;
    endfunction

    function automatic instr_t observe();
        return mk(out_op, out_arg, out_len, out_pc, out_err);
    endfunction

    task automatic set_len(input int lo, input int hi, input int n, input bit s);
        for (int i = lo; i <= hi; i++) begin
            len_tab[i] = n;
            sgn_tab[i] = s;
        end
    endtask

    task automatic init_tables();
        for (int i = 0; i < 256; i++) begin
            len_tab[i] = 0; sgn_tab[i] = 1'b0; err_tab[i] = 1'b0;
        end
        set_len('h10, 'h10, 1, 1); set_len('h12, 'h12, 1, 0); set_len('h15, 'h19, 1, 0);
        set_len('h36, 'h3a, 1, 0); set_len('ha9, 'ha9, 1, 0); set_len('hbc, 'hbc, 1, 0);
        set_len('h11, 'h11, 2, 1); set_len('h13, 'h14, 2, 0); set_len('h84, 'h84, 2, 0);
        set_len('h99, 'ha8, 2, 1); set_len('hb2, 'hb8, 2, 0); set_len('hbb, 'hbb, 2, 0);
        set_len('hbd, 'hbd, 2, 0); set_len('hc0, 'hc1, 2, 0); set_len('hc6, 'hc7, 2, 1);
        set_len('hc5, 'hc5, 3, 0); set_len('hb9, 'hba, 4, 0); set_len('hc8, 'hc9, 4, 0);
        err_tab['haa] = 1'b1; err_tab['hab] = 1'b1; err_tab['hc4] = 1'b1; err_tab['hff] = 1'b1;
`ifdef EJ32_FVM_EXT_EN
        set_len('hca, 'hca, 2, 1); set_len('hcb, 'hcb, 4, 0);
`else
        for (int i = 'hca; i <= 'hd1; i++) err_tab[i] = 1'b1;
`endif
    endtask

    // Reference: instruction at pc, built from the length/sign tables with plain arithmetic.
    function automatic instr_t model_fetch(input logic [ASZ-1:0] pc);
        instr_t         r;
        longint         a;
        int             n;
        logic [ASZ-1:0] p;
        r.op = mem[pc];
        n    = len_tab[r.op];
        a    = 0;
        for (int i = 1; i <= n; i++) begin
            p = pc + ASZ'(i);
            a = a * 256 + longint'(mem[p]);
        end
        if (sgn_tab[r.op] && n > 0 && a >= (longint'(1) << (8 * n - 1)))
            a = a - (longint'(1) << (8 * n));
        r.arg = a[DSZ-1:0];
        r.len = 3'(n);
        r.pc  = pc;
        r.err = err_tab[r.op];
        return r;
    endfunction

    // One clock; the memory answers the registered request during the low phase.
    task automatic cycle();
        @(negedge clk);
        if (mem_req && stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
        end else if (mem_req && int'($urandom_range(99)) >= stall_pct) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_adr];
        end else begin
            mem_ack = 1'b0;
        end
        if (!mem_ack) mem_data = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0; jmp = 1'b0; out_ready = 1'b0; stall_left = 0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string name, output int k);
        k = 0;
        while (!out_valid && k < 200) begin
            cycle();
            k++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL %s: out_valid got 0 after %0d cycles, required 1", name, k);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic test_reset();
        logic [ASZ+DSZ+2*8-1:0] got;
        rst = 1'b0;
        cycle();
        cycle();
        got = {mem_req, mem_adr, out_valid, out_op, out_arg, out_len, out_pc, out_err};
        n_checks++;
        if (got !== {1'b0, 16'h0000, 1'b0, 8'h00, 32'h0, 3'd0, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h required all-zero", got);
        end
        rst = 1'b1;
        cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_req: mem_req=%b mem_adr=%h, required 1 / 0000", mem_req, mem_adr);
        end
    endtask

    task automatic test_bipush();
        int k;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'hff;
        do_reset();
        out_ready = 1'b1;
        wait_valid("bipush_valid", k);
        n_checks++;
        if (observe() !== mk(8'h10, 32'hffff_ffff, 3'd1, 16'h0000, 1'b0)) begin
            n_fail++;
            $display("FAIL bipush: got %h required %h", observe(), mk(8'h10, 32'hffff_ffff, 3'd1, 16'h0, 1'b0));
        end
        cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 16'h0002 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bipush_next: req=%b adr=%h valid=%b, required 1/0002/0", mem_req, mem_adr, out_valid);
        end
    endtask

    task automatic test_sipush_goto();
        int k;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
        mem[3] = 8'ha7; mem[4] = 8'hff; mem[5] = 8'hfd;
        do_reset();
        out_ready = 1'b1;
        wait_valid("sipush_valid", k);
        n_checks++;
        if (observe() !== mk(8'h11, 32'h0000_1234, 3'd2, 16'h0000, 1'b0)) begin
            n_fail++;
            $display("FAIL sipush: got %h required %h", observe(), mk(8'h11, 32'h1234, 3'd2, 16'h0, 1'b0));
        end
        cycle();
        wait_valid("goto_valid", k);
        n_checks++;
        if (observe() !== mk(8'ha7, 32'hffff_fffd, 3'd2, 16'h0003, 1'b0)) begin
            n_fail++;
            $display("FAIL goto: got %h required %h", observe(), mk(8'ha7, 32'hffff_fffd, 3'd2, 16'h3, 1'b0));
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL goto_latency: got %0d cycles to out_valid, required 3", k);
        end
    endtask

    task automatic test_ext();
        int     k;
        instr_t exp;
        logic [ASZ-1:0] nxt;
        clear_mem();
        mem[0] = 8'hcb; mem[1] = 8'hde; mem[2] = 8'had; mem[3] = 8'hbe; mem[4] = 8'hef;
`ifdef EJ32_FVM_EXT_EN
        exp = mk(8'hcb, 32'hdead_beef, 3'd4, 16'h0, 1'b0);
        nxt = 16'h0005;
`else
        exp = mk(8'hcb, 32'h0, 3'd0, 16'h0, 1'b1);
        nxt = 16'h0001;
`endif
        do_reset();
        out_ready = 1'b1;
        wait_valid("ext_valid", k);
        n_checks++;
        if (observe() !== exp) begin
            n_fail++;
            $display("FAIL ext_opcode: got %h required %h", observe(), exp);
        end
        cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== nxt) begin
            n_fail++;
            $display("FAIL ext_next: req=%b adr=%h, required 1/%h", mem_req, mem_adr, nxt);
        end
    endtask

    task automatic test_backpressure();
        int     k;
        instr_t snap;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hab; mem[2] = 8'hcd;
        do_reset();
        cycle();
        stall_left = 3;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (mem_req !== 1'b1 || mem_adr !== 16'h0001 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL arg_stall[%0d]: req=%b adr=%h valid=%b, required 1/0001/0", i, mem_req, mem_adr, out_valid);
            end
        end
        wait_valid("stall_valid", k);
        n_checks++;
        if (observe() !== model_fetch(16'h0000)) begin
            n_fail++;
            $display("FAIL stall_operand: got %h required %h", observe(), model_fetch(16'h0000));
        end
        snap = observe();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (observe() !== snap || out_valid !== 1'b1 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h valid=%b req=%b, required %h/1/0", i, observe(), out_valid, mem_req, snap);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_adr !== 16'h0003) begin
            n_fail++;
            $display("FAIL release: valid=%b req=%b adr=%h, required 0/1/0003", out_valid, mem_req, mem_adr);
        end
    endtask

    task automatic test_jmp();
        int k;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
        mem[16'h100] = 8'h10; mem[16'h101] = 8'h05;
        do_reset();
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (mem_adr !== 16'h0002 || mem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_setup: adr=%h ack=%b, required 0002/1", mem_adr, mem_ack);
        end
        jmp = 1'b1; jmp_pc = 16'h0100;
        cycle();
        jmp = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 16'h0100 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_redirect: req=%b adr=%h valid=%b, required 1/0100/0", mem_req, mem_adr, out_valid);
        end
        wait_valid("jmp_valid", k);
        n_checks++;
        if (observe() !== mk(8'h10, 32'h5, 3'd1, 16'h0100, 1'b0)) begin
            n_fail++;
            $display("FAIL jmp_target: got %h required %h", observe(), mk(8'h10, 32'h5, 3'd1, 16'h0100, 1'b0));
        end
    endtask

    task automatic test_wrap();
        int k;
        clear_mem();
        mem[0] = 8'h01; mem[16'hfffe] = 8'h11; mem[16'hffff] = 8'h80; mem[1] = 8'h00;
        mem[0] = 8'h01;
        do_reset();
        out_ready = 1'b0;
        cycle();
        jmp = 1'b1; jmp_pc = 16'hfffe;
        cycle();
        jmp = 1'b0;
        out_ready = 1'b1;
        wait_valid("wrap_valid", k);
        n_checks++;
        if (observe() !== mk(8'h11, 32'hffff_8001, 3'd2, 16'hfffe, 1'b0)) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h required %h", observe(), mk(8'h11, 32'hffff_8001, 3'd2, 16'hfffe, 1'b0));
        end
        cycle();
        n_checks++;
        if (mem_adr !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_next: adr=%h required 0001", mem_adr);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [ASZ+DSZ+2*8-1:0] got;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h7f;
        do_reset();
        wait_valid("pre_reset_valid", k);
        #2 rst = 1'b0;
        #1;
        got = {mem_req, mem_adr, out_valid, out_op, out_arg, out_len, out_pc, out_err};
        n_checks++;
        if (got !== {1'b0, 16'h0000, 1'b0, 8'h00, 32'h0, 3'd0, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h required all-zero", got);
        end
        cycle();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 16'h0000) begin
            n_fail++;
            $display("FAIL restart: req=%b adr=%h, required 1/0000", mem_req, mem_adr);
        end
    endtask

    task automatic test_random();
        logic [ASZ-1:0] model_pc;
        instr_t         exp;
        int             accepted;
        clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        stall_pct = 30;
        do_reset();
        model_pc = '0;
        accepted = 0;
        for (int c = 0; c < 4000; c++) begin
            cycle();
            if (out_valid) begin
                exp = model_fetch(model_pc);
                n_checks++;
                if (observe() !== exp || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got %h req=%b required %h req=0", c, observe(), mem_req, exp);
                end
            end
            out_ready = ($urandom_range(2) != 0);
            jmp       = ($urandom_range(39) == 0);
            jmp_pc    = ASZ'($urandom_range(1000));
            if (out_valid && out_ready) begin
                model_pc = model_pc + 1'b1 + ASZ'(len_tab[exp.op]);
                accepted++;
            end
            if (jmp) model_pc = jmp_pc;
        end
        jmp = 1'b0;
        stall_pct = 0;
        n_checks++;
        if (accepted < 100) begin
            n_fail++;
            $display("FAIL random_progress: got %0d accepted, required at least 100", accepted);
        end
    endtask

    initial begin
        init_tables();
        clear_mem();
        test_reset();
        test_bipush();
        test_sipush_goto();
        test_ext();
        test_backpressure();
        test_jmp();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ej32_ifetch.md
# ej32_ifetch

Bytecode fetch and operand-assembly unit for the eJ32 core. It reads opcode and operand bytes one at a time from the 8-bit program memory, starting at the current PC. It classifies each opcode by operand length and assembles the big-endian operand bytes into a 32-bit argument. It then presents one complete instruction to the execute stage over a valid/ready handshake, and accepts PC redirects from execute for taken branches, calls and returns.

## Interface
- `RST_PC`, default 0: byte address fetched first after reset (`ASZ` bits).
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_req`  out  1: byte read request; held with `mem_adr` until acked.
- `mem_adr`  out  `ASZ`: byte address of the request.
- `mem_ack`  in  1: `mem_data` is valid this cycle; completes the request.
- `mem_data`  in  8: returned byte.
- `jmp`  in  1: redirect strobe, one cycle.
- `jmp_pc`  in  `ASZ`: redirect target.
- `out_valid`  out  1: an instruction is presented.
- `out_ready`  in  1: execute accepts the instruction.
- `out_op`  out  8: opcode byte (`opcode_t` encoding).
- `out_arg`  out  `DSZ`: assembled operand.
- `out_len`  out  3: operand byte count, 0..4.
- `out_pc`  out  `ASZ`: address of the opcode byte.
- `out_err`  out  1: the opcode is unsupported.

## Operation
- FSM states: OP (fetch opcode), ARG (fetch operand bytes), OUT (present instruction).
- From reset, the FSM enters OP with pc = `RST_PC`.
- OP
  - `mem_req`=1 and `mem_adr`=pc.
  - On `mem_ack`: latch the opcode, pc+1, and decode the length n.
  - n=0 goes to OUT; otherwise go to ARG with a count of n.
- ARG
  - Each ack shifts the byte in, big-endian: arg = {arg[23:0], byte}. It also increments pc and decrements the count.
  - When the last byte is shifted in, go to OUT.
- OUT
  - `out_valid`=1 and `mem_req`=0. All `out_*` outputs are held stable until `out_ready`=1; then go to OP.
- Operand length table
  - 1 byte: bipush, ldc, iload..aload (0x15-0x19), istore..astore (0x36-0x3a), ret, newarray.
  - 2 bytes: sipush, ldc_w, ldc2_w, iinc, ifeq..if_acmpne (0x99-0xa6), goto, jsr, getstatic..invokestatic (0xb2-0xb8), jnew, anewarray, checkcast, instanceof, ifnull, ifnotnull.
  - 3 bytes: multianewarray.
  - 4 bytes: invokeinterface, invokedynamic, goto_w, jsr_w.
  - Everything else: 0 bytes.
- Error opcodes: tableswitch, lookupswitch, wide, and 0xff have length 0 and `out_err`=1.
- Sign extension
  - bipush, sipush, all 2-byte branches (0x99-0xa8, ifnull, ifnotnull) and donext are sign-extended from 8·n bits.
  - All other operands are zero-extended.
- `out_arg` = 0 when n=0.
- pc wraps modulo 2^`ASZ`.
- Redirect
  - `jmp`=1 in any state sets pc = `jmp_pc`, clears `out_valid` and the count, and enters OP next cycle.
  - A `mem_ack` in the same cycle as `jmp` is discarded.
  - `jmp` together with `out_valid`&`out_ready` counts as an accepted transfer, then the redirect applies.
- The block does not act on branch semantics itself; only `jmp` changes the flow.

## Timing
- Reset values: `mem_req`=0, `mem_adr`=`RST_PC`, `out_valid`=0, `out_op`=0, `out_arg`=0, `out_len`=0, `out_pc`=0, `out_err`=0.
- `mem_req` first rises in the first cycle after reset deassertion.
- `mem_ack` is same-cycle: the memory responds combinationally or stalls with `mem_ack`=0 for any number of cycles. There is never more than one outstanding request.
- With zero-wait memory, an instruction with n operand bytes takes n+1 fetch cycles, then `out_valid` is registered the following cycle.
- Minimum issue interval is n+2 cycles.
- Redirect latency: `mem_adr`=`jmp_pc` with `mem_req`=1 on the cycle after `jmp`.
- Asserting reset mid-ARG or mid-OUT aborts immediately; all outputs return to their reset values asynchronously.

## Configuration
- `EJ32_FVM_EXT_EN`
  - Defined: the FVM extended opcodes decode as donext = 2 bytes (signed) and ldi = 4 bytes. popr, pushr, dupr, ext, get and put are 0 bytes, `out_err`=0.
  - Undefined: 0xca-0xd1 are length 0 with `out_err`=1.

## Test plan
- Memory at 0 holds 10 FF; `out_ready`=1 → `out_op`=0x10, `out_arg`=0xFFFFFFFF, `out_len`=1, `out_pc`=0; the next fetch is at address 2.
- Memory at 0 holds 11 12 34 A7 FF FD → sipush gives `out_arg`=0x00001234; goto gives `out_arg`=0xFFFFFFFD and `out_pc`=3.
- Memory holds cb DE AD BE EF → with the macro: `out_len`=4, `out_arg`=0xDEADBEEF. Without the macro: `out_len`=0, `out_err`=1, and the next fetch is at pc+1.
- `out_ready`=0 for 5 cycles while `out_valid`=1 → all `out_*` outputs stable and `mem_req`=0; `mem_ack` stalled for 3 cycles mid-ARG → the operand is assembled correctly.
- `jmp` with `jmp_pc`=0x100 during the second operand byte of sipush, with `mem_ack` in the same cycle → no instruction is issued and the next `mem_adr` is 0x100.
- Reset asserted while `out_valid`=1 → all outputs at reset values; after release, fetch restarts at `RST_PC`.
